// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared op/state encodings and default widths for the multiply/divide unit.
package mdu_ctrl_pkg;

    localparam int MDU_DW    = 32;
    localparam int MDU_CNT_W = 6;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_SIGN = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// mdu_iter_core: one radix-2 shift-add (multiply) or restoring shift-subtract (divide) step.
module mdu_iter_core
    import mdu_ctrl_pkg::*;
#(
    parameter int DW = MDU_DW
) (
    input  logic [2*DW-1:0] acc,
    input  logic [DW-1:0]   opnd,
    input  logic            is_div,
    output logic [2*DW-1:0] acc_nxt
);

    logic [DW:0]   sum;
    logic [DW:0]   shl;
    logic          ge;
    logic [DW-1:0] sub;

    // Divide layout is {remainder, quotient}; the remainder never reaches the divisor, so DW bits suffice.
    always_comb begin
        sum     = {1'b0, acc[2*DW-1:DW]} + {1'b0, (acc[0] ? opnd : '0)};
        shl     = acc[2*DW-1:DW-1];
        ge      = shl >= {1'b0, opnd};
        sub     = shl[DW-1:0] - opnd;
        acc_nxt = is_div ? (ge ? {sub, acc[DW-2:0], 1'b1} : {shl[DW-1:0], acc[DW-2:0], 1'b0})
                         : {sum, acc[DW-1:1]};
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning the architectural HI/LO registers.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int            DW      = MDU_DW,
    parameter int            CNT_W   = MDU_CNT_W,
    parameter logic [DW-1:0] DIV0_LO = '1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    input  logic          flush,
    input  logic          hi_we,
    input  logic          lo_we,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2*DW-1:0] acc_q, acc_d, step_acc;
    logic [DW-1:0]   opnd_q, opnd_d;
    logic            div_q, div_d;
    logic            negp_q, negp_d;
    logic            negr_q, negr_d;
    logic            div0_q, div0_d;
    logic            done_q, done_d;
    logic [DW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic            issue, commit, sa, sb;
    logic [DW-1:0]   mag_a, mag_b, quo, rem;
    logic [2*DW-1:0] prod;

    mdu_iter_core #(.DW(DW)) u_core (
        .acc    (acc_q),
        .opnd   (opnd_q),
        .is_div (div_q),
        .acc_nxt(step_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = flush ? S_IDLE
                : state_q == S_IDLE ? (start ? S_CALC : S_IDLE)
                : state_q == S_CALC ? (count_q == CNT_W'(1) ? S_SIGN : S_CALC)
                : S_IDLE;
    end

    always_comb begin
        busy = (state_q != S_IDLE) | (start & ~flush);
    end

    always_comb begin
        issue   = start & (state_q == S_IDLE) & ~flush;
        commit  = (state_q == S_SIGN) & ~flush;
        sa      = ~op[0] & src_a[DW-1];
        sb      = ~op[0] & src_b[DW-1];
        mag_a   = sa ? -src_a : src_a;
        mag_b   = sb ? -src_b : src_b;
        count_d = issue ? CNT_W'(DW) : state_q == S_CALC ? count_q - CNT_W'(1) : count_q;
        acc_d   = issue ? {{DW{1'b0}}, (op[1] ? mag_a : mag_b)} : state_q == S_CALC ? step_acc : acc_q;
        opnd_d  = issue ? (op[1] ? mag_b : mag_a) : opnd_q;
        div_d   = issue ? op[1] : div_q;
        negp_d  = issue ? sa ^ sb : negp_q;
        negr_d  = issue ? sa : negr_q;
        div0_d  = issue ? op[1] & (src_b == '0) : div0_q;
        // A zero divisor leaves |src_a| as remainder, so the normal remainder sign fix restores raw src_a.
        prod    = negp_q ? -acc_q : acc_q;
        quo     = div0_q ? DIV0_LO : negp_q ? -acc_q[DW-1:0] : acc_q[DW-1:0];
        rem     = negr_q ? -acc_q[2*DW-1:DW] : acc_q[2*DW-1:DW];
        hi_d    = commit ? (div_q ? rem : prod[2*DW-1:DW]) : hi_we ? wdata : hi_q;
        lo_d    = commit ? (div_q ? quo : prod[DW-1:0]) : lo_we ? wdata : lo_q;
        done_d  = commit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            negp_q  <= negp_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed checks of mdu_ctrl results, latency, flush, MTHI/MTLO and reset.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int lat, bcyc, seen;

    mdu_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one op and waits (bounded) for done; lat counts edges after the issue edge.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bc);
        op = o; src_a = a; src_b = b; start = 1'b1;
        #1;
        bc = busy ? 1 : 0;
        tick();
        start = 1'b0;
        l = 0;
        while (!done && l < 100) begin
            if (busy) bc++;
            tick();
            l++;
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("reset_hi", hi, 32'h0);
        chk("reset_lo", lo, 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);

        do_op(MDU_MULT, 32'hFFFFFFFD, 32'h5, lat, bcyc);
        chk("mult_latency", 32'(lat), 32'd33);
        chk("mult_busy_cycles", 32'(bcyc), 32'd34);
        chk("mult_busy_at_done", 32'(busy), 32'h0);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        tick();
        chk("done_one_cycle", 32'(done), 32'h0);

        do_op(MDU_DIVU, 32'd100, 32'd7, lat, bcyc);
        chk("divu_lo", lo, 32'h0000000E);
        chk("divu_hi", hi, 32'h00000002);

        do_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, lat, bcyc);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);

        do_op(MDU_DIV, 32'h12345678, 32'h0, lat, bcyc);
        chk("div0_latency", 32'(lat), 32'd33);
        chk("div0_lo", lo, 32'hFFFFFFFF);
        chk("div0_hi", hi, 32'h12345678);

        do_op(MDU_DIVU, 32'h12345678, 32'h0, lat, bcyc);
        chk("divu0_latency", 32'(lat), 32'd33);
        chk("divu0_lo", lo, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'h12345678);

        do_op(MDU_DIV, 32'h80000005, 32'h0, lat, bcyc);
        chk("div0_neg_lo", lo, 32'hFFFFFFFF);
        chk("div0_neg_hi", hi, 32'h80000005);

        do_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bcyc);
        chk("div_ovf_lo", lo, 32'h80000000);
        chk("div_ovf_hi", hi, 32'h0);

        do_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bcyc);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        do_op(MDU_MULT, 32'h00001234, 32'hFFFFFFFE, lat, bcyc);
        chk("b2b_latency", 32'(lat), 32'd33);
        chk("b2b_hi", hi, 32'hFFFFFFFF);
        chk("b2b_lo", lo, 32'hFFFFDB98);

        hi_we = 1'b1; wdata = 32'hAAAA0000;
        tick();
        hi_we = 1'b0;
        chk("mthi", hi, 32'hAAAA0000);
        op = MDU_DIV; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("busy_before_flush", 32'(busy), 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'h0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        chk("flush_no_done", 32'(seen), 32'h0);
        chk("flush_hi_kept", hi, 32'hAAAA0000);

        op = MDU_MULTU; start = 1'b1; flush = 1'b1;
        #1;
        chk("start_flush_busy", 32'(busy), 32'h0);
        tick();
        start = 1'b0; flush = 1'b0;
        chk("start_flush_not_issued", 32'(busy), 32'h0);

        op = MDU_MULTU; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        lo_we = 1'b1; wdata = 32'h55;
        tick();
        lo_we = 1'b0;
        chk("mtlo_in_calc", lo, 32'h55);
        chk("mtlo_still_busy", 32'(busy), 32'h1);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        chk("mtlo_done_seen", 32'(done), 32'h1);
        chk("mtlo_overwritten_lo", lo, 32'd12);
        chk("mtlo_overwritten_hi", hi, 32'h0);

        do_op(MDU_MULTU, 32'd7, 32'd9, lat, bcyc);
        chk("pre_rst_lo", lo, 32'd63);
        op = MDU_DIVU; src_a = 32'd50; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_no_done", 32'(done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
